// File: rtl/instruction_fetch_unit_pkg.sv
// rtl/instruction_fetch_unit_pkg.sv - shared fetch/decode constants and FSM state encoding
package instruction_fetch_unit_pkg;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] HALT_SENTINEL     = 32'h0000_0000;

    function automatic logic is_halt_word(input logic [31:0] word);
        return word == HALT_SENTINEL;
    endfunction

endpackage

// File: rtl/instruction_memory.sv
// rtl/instruction_memory.sv - word-addressed instruction ROM with combinational read
module instruction_memory #(
    parameter int                      DEPTH = 64,
    parameter logic [32*DEPTH-1:0]     INIT  = '0
) (
    input  logic [$clog2(DEPTH)-1:0] addr,
    output logic [31:0]              rdata
);

    // Contents are fixed at elaboration from the packed image; reset never touches them.
    logic [31:0] mem [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        assign mem[i] = INIT[32*i +: 32];
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC, run/halt FSM and IF/ID register
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int                        IMEM_DEPTH = 64,
    parameter logic [63:0]               RESET_PC   = 64'h0,
    parameter logic [31:0]               NOP_INSTR  = DEFAULT_NOP_INSTR,
    parameter logic [32*IMEM_DEPTH-1:0]  IMEM_INIT  = '0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [63:0] branch_target,
    output logic [31:0] if_id_instruction,
    output logic [63:0] if_id_pc,
    output logic        if_id_valid,
    output logic [63:0] pc,
    output logic        halted,
    output logic        misaligned,
    output logic [31:0] fetch_count
);

    localparam int AW = $clog2(IMEM_DEPTH);

    fetch_state_t state;
    logic [31:0]  fetch_word;

    // Upper PC bits are dropped so fetches wrap modulo the memory size.
    instruction_memory #(
        .DEPTH (IMEM_DEPTH),
        .INIT  (IMEM_INIT)
    ) u_imem (
        .addr  (pc[AW+1:2]),
        .rdata (fetch_word)
    );

    assign halted = (state == ST_HALTED);

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= ST_RUN;
            pc                <= RESET_PC;
            if_id_instruction <= NOP_INSTR;
            if_id_pc          <= 64'h0;
            if_id_valid       <= 1'b0;
            misaligned        <= 1'b0;
            fetch_count       <= 32'h0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (branch_taken) begin
                        pc                <= {branch_target[63:2], 2'b00};
                        if_id_instruction <= NOP_INSTR;
                        if_id_valid       <= 1'b0;
                        if (branch_target[1:0] != 2'b00) begin
                            misaligned <= 1'b1;
                        end
                    end else if (!stall) begin
                        if (is_halt_word(fetch_word)) begin
                            state             <= ST_HALTED;
                            if_id_instruction <= NOP_INSTR;
                            if_id_valid       <= 1'b0;
                        end else begin
                            if_id_instruction <= fetch_word;
                            if_id_pc          <= pc;
                            if_id_valid       <= 1'b1;
                            pc                <= pc + 64'd4;
                            fetch_count       <= fetch_count + 32'd1;
                        end
                    end
                end
                default: begin
                    // Halted: everything frozen until reset.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed vector bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

    localparam int DEPTH = 64;

    function automatic logic [32*DEPTH-1:0] build_image();
        logic [32*DEPTH-1:0] img;
        img = '0;
        img[32*0  +: 32] = 32'h0050_0093;
        img[32*1  +: 32] = 32'h00A0_0113;
        img[32*2  +: 32] = 32'h0020_81B3;
        img[32*8  +: 32] = 32'h1111_1111;
        img[32*9  +: 32] = 32'h2222_2222;
        img[32*63 +: 32] = 32'h3333_3333;
        return img;
    endfunction

    localparam logic [32*DEPTH-1:0] IMAGE = build_image();
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [63:0] branch_target = 64'h0;
    logic [31:0] if_id_instruction;
    logic [63:0] if_id_pc;
    logic        if_id_valid;
    logic [63:0] pc;
    logic        halted;
    logic        misaligned;
    logic [31:0] fetch_count;

    instruction_fetch_unit #(
        .IMEM_DEPTH (DEPTH),
        .RESET_PC   (64'h0),
        .NOP_INSTR  (NOP),
        .IMEM_INIT  (IMAGE)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .stall             (stall),
        .branch_taken      (branch_taken),
        .branch_target     (branch_target),
        .if_id_instruction (if_id_instruction),
        .if_id_pc          (if_id_pc),
        .if_id_valid       (if_id_valid),
        .pc                (pc),
        .halted            (halted),
        .misaligned        (misaligned),
        .fetch_count       (fetch_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stl;
        logic        br;
        logic [63:0] tgt;
        logic [63:0] e_pc;
        logic [31:0] e_ins;
        logic [63:0] e_ipc;
        logic        e_v;
        logic        e_h;
        logic        e_m;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   passed = 0;

    task automatic check(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    endtask

    task automatic check_all(input int idx, input vec_t v);
        check("pc",          idx, pc,                       v.e_pc);
        check("if_id_instr", idx, {32'h0, if_id_instruction}, {32'h0, v.e_ins});
        check("if_id_pc",    idx, if_id_pc,                 v.e_ipc);
        check("if_id_valid", idx, {63'h0, if_id_valid},     {63'h0, v.e_v});
        check("halted",      idx, {63'h0, halted},          {63'h0, v.e_h});
        check("misaligned",  idx, {63'h0, misaligned},      {63'h0, v.e_m});
        check("fetch_count", idx, {32'h0, fetch_count},     {32'h0, v.e_cnt});
    endtask

    task automatic apply(input vec_t v);
        reset         = v.rst;
        stall         = v.stl;
        branch_taken  = v.br;
        branch_target = v.tgt;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            rst   stl   br    tgt         pc          ins           ipc         v     h     m     cnt
        vecs.push_back('{1'b1, 1'b0, 1'b0, 64'h0,   64'h0,   NOP,          64'h0,   1'b0, 1'b0, 1'b0, 32'd0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 64'h0,   64'h4,   32'h00500093, 64'h0,   1'b1, 1'b0, 1'b0, 32'd1});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 64'h0,   64'h8,   32'h00A00113, 64'h4,   1'b1, 1'b0, 1'b0, 32'd2});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 64'h0,   64'hC,   32'h002081B3, 64'h8,   1'b1, 1'b0, 1'b0, 32'd3});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 64'h0,   64'hC,   NOP,          64'h8,   1'b0, 1'b1, 1'b0, 32'd3});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 64'h0,   64'hC,   NOP,          64'h8,   1'b0, 1'b1, 1'b0, 32'd3});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 64'h0,   64'h0,   NOP,          64'h0,   1'b0, 1'b0, 1'b0, 32'd0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 64'h0,   64'h4,   32'h00500093, 64'h0,   1'b1, 1'b0, 1'b0, 32'd1});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 64'h0,   64'h4,   32'h00500093, 64'h0,   1'b1, 1'b0, 1'b0, 32'd1});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 64'h0,   64'h4,   32'h00500093, 64'h0,   1'b1, 1'b0, 1'b0, 32'd1});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 64'h0,   64'h8,   32'h00A00113, 64'h4,   1'b1, 1'b0, 1'b0, 32'd2});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 64'h20,  64'h20,  NOP,          64'h4,   1'b0, 1'b0, 1'b0, 32'd2});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 64'h0,   64'h24,  32'h11111111, 64'h20,  1'b1, 1'b0, 1'b0, 32'd3});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 64'h22,  64'h20,  NOP,          64'h20,  1'b0, 1'b0, 1'b1, 32'd3});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 64'h0,   64'h24,  32'h11111111, 64'h20,  1'b1, 1'b0, 1'b1, 32'd4});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 64'h0,   64'h24,  32'h11111111, 64'h20,  1'b1, 1'b0, 1'b1, 32'd4});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 64'h0,   64'h28,  32'h22222222, 64'h24,  1'b1, 1'b0, 1'b1, 32'd5});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 64'h0,   64'h28,  NOP,          64'h24,  1'b0, 1'b1, 1'b1, 32'd5});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 64'h100, 64'h28,  NOP,          64'h24,  1'b0, 1'b1, 1'b1, 32'd5});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 64'h22,  64'h0,   NOP,          64'h0,   1'b0, 1'b0, 1'b0, 32'd0});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 64'h100, 64'h100, NOP,          64'h0,   1'b0, 1'b0, 1'b0, 32'd0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 64'h0,   64'h104, 32'h00500093, 64'h100, 1'b1, 1'b0, 1'b0, 32'd1});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 64'h0,   64'h0,   NOP,          64'h0,   1'b0, 1'b0, 1'b0, 32'd0});

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
            check_all(i, vecs[i]);
        end

        // PC wraps modulo 2^64 after fetching the top word of the address space.
        reset = 1'b0; stall = 1'b0;
        branch_taken = 1'b1; branch_target = 64'hFFFF_FFFF_FFFF_FFFC;
        @(posedge clk); #1;
        check("wrap_redirect_pc", 100, pc, 64'hFFFF_FFFF_FFFF_FFFC);
        branch_taken = 1'b0; branch_target = 64'h0;
        @(posedge clk); #1;
        check("wrap_pc",    101, pc, 64'h0);
        check("wrap_instr", 101, {32'h0, if_id_instruction}, {32'h0, 32'h3333_3333});
        check("wrap_ipc",   101, if_id_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        check("wrap_count", 101, {32'h0, fetch_count}, 64'd1);

        // Reset held for several cycles keeps the reset state; first fetch on the edge after release.
        reset = 1'b1; stall = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("held_reset_pc", 102, pc, 64'h0);
        reset = 1'b0; stall = 1'b0;
        @(posedge clk); #1;
        check("post_reset_ipc",   103, if_id_pc, 64'h0);
        check("post_reset_valid", 103, {63'h0, if_id_valid}, 64'd1);
        check("post_reset_pc",    103, pc, 64'h4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
